reg_file_mp: RTL and testbench

Parametrised multi-port register file for the pipeline's decode stage. It generalises the 2-read/1-write file to NUM_RD read ports and NUM_WR write ports, with configurable data width and depth. It adds per-port read enables, an optional hardwired zero register, deterministic write-port priority, and a sticky write-collision flag. Writes commit on the rising edge; read data registers on the falling edge, so a write is readable in the same cycle.

---
 rtl/reg_file_mp_if.sv | 29 ++
 rtl/reg_file_mp.sv | 97 +++++++++
 tb/tb_reg_file_mp.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports
// and the sticky collision flag. The pipeline drives through 'master';
// the register file sits behind 'slave'.
`timescale 1ns/1ps

interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]        write;
    logic [NUM_WR*ADDR_W-1:0] WR;
    logic [NUM_WR*DATA_W-1:0] WD;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] PR;
    logic [NUM_RD*DATA_W-1:0] RD;
    logic                     collision_err;

    modport master (
        output write, WR, WD, rd_en, PR,
        input  RD, collision_err
    );

    modport slave (
        input  write, WR, WD, rd_en, PR,
        output RD, collision_err
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file for the decode stage. Writes commit on the
// rising edge and reads register on the falling edge, so data written at
// a rising edge reaches RD at the falling edge of the same cycle without
// a bypass path. When several write ports hit one address the highest
// index port wins and the sticky collision flag is raised.
`timescale 1ns/1ps

module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          reset,
    reg_file_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_image_t;

    // Reset image: every entry holds its own index, zero-extended.
    function automatic mem_image_t init_image();
        mem_image_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DATA_W'(i);
        end
        return img;
    endfunction

    localparam mem_image_t RESET_IMAGE = init_image();

    mem_image_t        rf_mem;
    logic [NUM_WR-1:0] wr_live;
    logic              collision_now;

    // A write port is live when enabled and not aimed at the hardwired zero register.
    always_comb begin
        wr_live = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_live[k] = bus.write[k] &&
                         !((ZERO_REG != 0) && (bus.WR[k*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Flag any pair of live write ports targeting the same address this cycle.
    always_comb begin
        collision_now = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_live[a] && wr_live[b] &&
                    (bus.WR[a*ADDR_W +: ADDR_W] == bus.WR[b*ADDR_W +: ADDR_W])) begin
                    collision_now = 1'b1;
                end
            end
        end
    end

    // Commit writes in ascending port order so the highest index port lands last and wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_mem <= RESET_IMAGE;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_live[k]) begin
                    rf_mem[bus.WR[k*ADDR_W +: ADDR_W]] <= bus.WD[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.collision_err <= 1'b0;
        end else if (collision_now) begin
            bus.collision_err <= 1'b1;
        end
    end

    // Register read data on the falling edge; a disabled port keeps its last value.
    // Entry 0 needs no read mux when hardwired: it resets to 0 and is never written.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            bus.RD <= '0;
        end else begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (bus.rd_en[j]) begin
                    bus.RD[j*DATA_W +: DATA_W] <= rf_mem[bus.PR[j*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Three instances share clock and reset:
// the default configuration, the same with address 0 as an ordinary
// register, and a narrow 16-bit, 8-entry, 4-read/1-write variant.
`timescale 1ns/1ps

module tb_reg_file_mp;

    logic clk;
    logic reset;

    int vec_count;
    int miss_count;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_a ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_b ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .NUM_WR(1)) if_c ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1)) u_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c.slave)
    );

    // Free-running 10 ns clock; rising edges at 5, 15, ... and falling edges at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vec_count++;
        assert (observed === expected)
        else begin
            miss_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full cycle: writes commit at the rising edge, reads at the falling edge, then settle.
    task automatic apply_stimulus();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Drop every write enable on all instances.
    task automatic clear_writes();
        if_a.write = '0;
        if_b.write = '0;
        if_c.write = '0;
    endtask

    // Linear sequence of directed steps.
    initial begin
        vec_count  = 0;
        miss_count = 0;
        reset = 1'b1;
        if_a.write = '0; if_a.WR = '0; if_a.WD = '0; if_a.rd_en = '0; if_a.PR = '0;
        if_b.write = '0; if_b.WR = '0; if_b.WD = '0; if_b.rd_en = '0; if_b.PR = '0;
        if_c.write = '0; if_c.WR = '0; if_c.WD = '0; if_c.rd_en = '0; if_c.PR = '0;

        #12;
        check_output("reset_a_rd0", if_a.RD[31:0], 32'd0);
        check_output("reset_a_rd1", if_a.RD[63:32], 32'd0);
        check_output("reset_a_coll", {31'd0, if_a.collision_err}, 32'd0);
        check_output("reset_c_rd3", {16'd0, if_c.RD[63:48]}, 32'd0);
        reset = 1'b0;

        // First reads after reset come from the initialised memory.
        if_a.rd_en = 2'b11; if_a.PR = {5'd8, 5'd6};
        if_b.rd_en = 2'b01; if_b.PR = {5'd3, 5'd0};
        if_c.rd_en = 4'b1111; if_c.PR = {3'd5, 3'd0, 3'd7, 3'd7};
        apply_stimulus();
        check_output("init_a_rd0", if_a.RD[31:0], 32'd6);
        check_output("init_a_rd1", if_a.RD[63:32], 32'd8);
        check_output("init_b_rd0_addr0", if_b.RD[31:0], 32'd0);
        check_output("init_c_rd0", {16'd0, if_c.RD[15:0]}, 32'd7);
        check_output("init_c_rd1", {16'd0, if_c.RD[31:16]}, 32'd7);
        check_output("init_c_rd2", {16'd0, if_c.RD[47:32]}, 32'd0);
        check_output("init_c_rd3", {16'd0, if_c.RD[63:48]}, 32'd5);

        // Read enables low: RD holds while addresses move.
        if_a.rd_en = 2'b00; if_a.PR = {5'd4, 5'd3};
        if_c.rd_en = 4'b0000;
        apply_stimulus();
        check_output("hold_a_rd0", if_a.RD[31:0], 32'd6);
        check_output("hold_a_rd1", if_a.RD[63:32], 32'd8);

        // Same-cycle write-through on both designs.
        if_a.write = 2'b01; if_a.WR = {5'd0, 5'd4}; if_a.WD = {32'd0, 32'd31};
        if_a.rd_en = 2'b01; if_a.PR = {5'd4, 5'd4};
        if_c.write = 1'b1; if_c.WR = 3'd7; if_c.WD = 16'hFFFF;
        if_c.rd_en = 4'b1111; if_c.PR = {3'd5, 3'd0, 3'd7, 3'd7};
        apply_stimulus();
        check_output("wthru_a_rd0", if_a.RD[31:0], 32'd31);
        check_output("wthru_a_rd1_held", if_a.RD[63:32], 32'd8);
        check_output("wthru_a_coll", {31'd0, if_a.collision_err}, 32'd0);
        check_output("wthru_c_rd0", {16'd0, if_c.RD[15:0]}, 32'h0000FFFF);
        check_output("wthru_c_rd1", {16'd0, if_c.RD[31:16]}, 32'h0000FFFF);
        check_output("wthru_c_rd2", {16'd0, if_c.RD[47:32]}, 32'd0);
        check_output("wthru_c_rd3", {16'd0, if_c.RD[63:48]}, 32'd5);
        if_c.write = 1'b0; if_c.rd_en = 4'b0000;

        // Both ports write address 9: port 1 wins and the flag sets.
        if_a.write = 2'b11; if_a.WR = {5'd9, 5'd9}; if_a.WD = {32'd200, 32'd100};
        if_a.rd_en = 2'b01; if_a.PR = {5'd0, 5'd9};
        apply_stimulus();
        check_output("coll_a_rd0", if_a.RD[31:0], 32'd200);
        check_output("coll_a_flag", {31'd0, if_a.collision_err}, 32'd1);

        // Non-colliding write afterwards: flag stays set.
        if_a.write = 2'b01; if_a.WR = {5'd0, 5'd12}; if_a.WD = {32'd0, 32'd5};
        if_a.rd_en = 2'b10; if_a.PR = {5'd12, 5'd0};
        apply_stimulus();
        check_output("sticky_a_rd1", if_a.RD[63:32], 32'd5);
        check_output("sticky_a_rd0_held", if_a.RD[31:0], 32'd200);
        check_output("sticky_a_flag", {31'd0, if_a.collision_err}, 32'd1);

        // Reset 2.5 ns after a rising edge that carries a write to address 10.
        if_a.write = 2'b01; if_a.WR = {5'd0, 5'd10}; if_a.WD = {32'd0, 32'd77};
        if_a.rd_en = 2'b01; if_a.PR = {5'd0, 5'd10};
        @(posedge clk);
        #2.5;
        reset = 1'b1;
        #1;
        check_output("midrst_a_rd0", if_a.RD[31:0], 32'd0);
        check_output("midrst_a_rd1", if_a.RD[63:32], 32'd0);
        check_output("midrst_a_flag", {31'd0, if_a.collision_err}, 32'd0);
        @(negedge clk);
        #1;
        check_output("inrst_a_rd0", if_a.RD[31:0], 32'd0);
        reset = 1'b0;
        clear_writes();
        apply_stimulus();
        check_output("postrst_a_addr10", if_a.RD[31:0], 32'd10);

        // Hardwired zero: writes to address 0 are dropped and never collide.
        if_a.write = 2'b11; if_a.WR = {5'd0, 5'd0}; if_a.WD = {32'd55, 32'd55};
        if_a.rd_en = 2'b11; if_a.PR = {5'd0, 5'd0};
        if_b.write = 2'b01; if_b.WR = {5'd0, 5'd0}; if_b.WD = {32'd0, 32'd55};
        if_b.rd_en = 2'b01; if_b.PR = {5'd0, 5'd0};
        apply_stimulus();
        check_output("zero_a_rd0", if_a.RD[31:0], 32'd0);
        check_output("zero_a_rd1", if_a.RD[63:32], 32'd0);
        check_output("zero_a_flag", {31'd0, if_a.collision_err}, 32'd0);
        check_output("plain0_b_rd0", if_b.RD[31:0], 32'd55);
        check_output("plain0_b_flag", {31'd0, if_b.collision_err}, 32'd0);

        // Without the zero register, address 0 collides like any other.
        if_a.write = 2'b00;
        if_b.write = 2'b11; if_b.WR = {5'd0, 5'd0}; if_b.WD = {32'd77, 32'd66};
        if_b.rd_en = 2'b11; if_b.PR = {5'd0, 5'd0};
        apply_stimulus();
        check_output("plain0_b_win_rd0", if_b.RD[31:0], 32'd77);
        check_output("plain0_b_win_rd1", if_b.RD[63:32], 32'd77);
        check_output("plain0_b_coll", {31'd0, if_b.collision_err}, 32'd1);
        clear_writes();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
